// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM that answers datapath read/write
// requests after a fixed LATENCY and signals completion with a one-cycle pulse.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] mdata_out,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              in_idle;
  logic              finish;
  logic              req_one;
  logic              req_both;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign in_idle  = (state == IDLE);
  assign finish   = (state == WAIT) && (cnt == 4'd0);
  assign req_one  = mem_read ^ mem_write;
  assign req_both = mem_read & mem_write;

  // mem_ready and busy decode straight from state, so an async clear drops
  // them immediately without waiting for a clock.
  assign mem_ready = (state == DONE);
  assign busy      = !in_idle;

  // Single RAM write port shared by the preload path (IDLE only) and the
  // completion of a latched write (WAIT, counter expired).
  // NOTE: every output of a combinational block gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ld_addr;
    ram_wdata = ld_data;
    if (in_idle && ld_en) begin
      ram_we = 1'b1;
    end else if (finish && lat_wr) begin
      ram_we    = 1'b1;
      ram_waddr = lat_addr;
      ram_wdata = lat_data;
    end
  end

  // NOTE: the RAM array has no reset; its contents must survive clr, and a
  // reset on a memory would also prevent mapping it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_wr    <= 1'b0;
      mdata_out <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          // A preload edge takes priority and blocks request acceptance.
          if (!ld_en) begin
            if (req_both) begin
              err <= 1'b1;
            end else if (req_one) begin
              lat_addr <= mar_addr;
              lat_data <= mdr_wdata;
              lat_wr   <= mem_write;
              cnt      <= CNT_INIT;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!lat_wr) begin
              mdata_out <= ram[lat_addr];
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: preload, read/write latency, illegal
// requests, mid-access input changes, async clear, and back-to-back streams.
module tb_mem_responder;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] mar_addr  = '0;
  logic [DW-1:0] mdr_wdata = '0;
  logic          mem_read  = 1'b0;
  logic          mem_write = 1'b0;
  logic          ld_en     = 1'b0;
  logic [AW-1:0] ld_addr   = '0;
  logic [DW-1:0] ld_data   = '0;
  logic [DW-1:0] mdata_out;
  logic          mem_ready, busy, err;

  logic          rd_l1  = 1'b0;
  logic          rd_l15 = 1'b0;
  logic [DW-1:0] mdata_l1, mdata_l15;
  logic          ready_l1, busy_l1, err_l1;
  logic          ready_l15, busy_l15, err_l15;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(2)) dut (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .mdata_out(mdata_out),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(1)) dut_l1 (
    .clk(clk), .clr(clr), .mar_addr(9'd0), .mdr_wdata(32'd0),
    .mem_read(rd_l1), .mem_write(1'b0), .ld_en(1'b0),
    .ld_addr(9'd0), .ld_data(32'd0), .mdata_out(mdata_l1),
    .mem_ready(ready_l1), .busy(busy_l1), .err(err_l1)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(15)) dut_l15 (
    .clk(clk), .clr(clr), .mar_addr(9'd0), .mdr_wdata(32'd0),
    .mem_read(rd_l15), .mem_write(1'b0), .ld_en(1'b0),
    .ld_addr(9'd0), .ld_data(32'd0), .mdata_out(mdata_l15),
    .mem_ready(ready_l15), .busy(busy_l15), .err(err_l15)
  );

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Present a request for exactly one edge (the acceptance edge k).
  task automatic start(input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mem_read  = rd;
    mem_write = wr;
    mar_addr  = addr;
    mdr_wdata = data;
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Full LATENCY=2 access on the main instance, ending back in IDLE.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
    start(rd, wr, addr, data);
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (mdata_out !== 32'd0) $display("FAIL reset_mdata got=%h exp=0", mdata_out); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", mem_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_read();
    preload(9'd5, 32'h0000_0012);
    start(1'b1, 1'b0, 9'd5, 32'd0);
    n_total++; if (busy !== 1'b1) $display("FAIL rd_busy_k got=%b exp=1", busy); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_k got=%b exp=0", mem_ready); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b1) $display("FAIL rd_busy_k1 got=%b exp=1", busy); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_k1 got=%b exp=0", mem_ready); else n_pass++;
    tick();
    n_total++; if (mem_ready !== 1'b1) $display("FAIL rd_ready_k2 got=%b exp=1", mem_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL rd_busy_k2 got=%b exp=1", busy); else n_pass++;
    n_total++; if (mdata_out !== 32'h0000_0012) $display("FAIL rd_data got=%h exp=00000012", mdata_out); else n_pass++;
    tick();
    n_total++; if (mem_ready !== 1'b0) $display("FAIL rd_ready_k3 got=%b exp=0", mem_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_busy_k3 got=%b exp=0", busy); else n_pass++;
    n_total++; if (mdata_out !== 32'h0000_0012) $display("FAIL rd_hold got=%h exp=00000012", mdata_out); else n_pass++;
  endtask

  task automatic test_write_read();
    start(1'b0, 1'b1, 9'd7, 32'h0000_0014);
    tick();
    tick();
    n_total++; if (mem_ready !== 1'b1) $display("FAIL wr_ready got=%b exp=1", mem_ready); else n_pass++;
    n_total++; if (mdata_out !== 32'h0000_0012) $display("FAIL wr_mdata_unchanged got=%h exp=00000012", mdata_out); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL wr_busy_end got=%b exp=0", busy); else n_pass++;
    run_access(1'b1, 1'b0, 9'd7, 32'd0);
    n_total++; if (mdata_out !== 32'h0000_0014) $display("FAIL wr_readback got=%h exp=00000014", mdata_out); else n_pass++;
  endtask

  task automatic test_illegal();
    start(1'b1, 1'b1, 9'd7, 32'hDEAD_BEEF);
    n_total++; if (err !== 1'b1) $display("FAIL ill_err got=%b exp=1", err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ill_busy got=%b exp=0", busy); else n_pass++;
    tick();
    n_total++; if (err !== 1'b0) $display("FAIL ill_err_drop got=%b exp=0", err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ill_busy2 got=%b exp=0", busy); else n_pass++;
    run_access(1'b1, 1'b0, 9'd7, 32'd0);
    n_total++; if (mdata_out !== 32'h0000_0014) $display("FAIL ill_ram_kept got=%h exp=00000014", mdata_out); else n_pass++;
  endtask

  task automatic test_wait_ignore();
    start(1'b1, 1'b0, 9'd5, 32'd0);
    mar_addr  = 9'd7;
    mdr_wdata = 32'h0BAD_F00D;
    mem_write = 1'b1;
    tick();
    tick();
    n_total++; if (mem_ready !== 1'b1) $display("FAIL ign_ready got=%b exp=1", mem_ready); else n_pass++;
    n_total++; if (mdata_out !== 32'h0000_0012) $display("FAIL ign_data got=%h exp=00000012", mdata_out); else n_pass++;
    mem_write = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL ign_busy got=%b exp=0", busy); else n_pass++;
    run_access(1'b1, 1'b0, 9'd7, 32'd0);
    n_total++; if (mdata_out !== 32'h0000_0014) $display("FAIL ign_no_write got=%h exp=00000014", mdata_out); else n_pass++;
  endtask

  task automatic test_async_clear();
    preload(9'd3, 32'h0000_0033);
    preload(9'd9, 32'hA5A5_0009);
    start(1'b0, 1'b1, 9'd3, 32'h9008_0000);
    #2 clr = 1'b0;
    #1;
    n_total++; if (mdata_out !== 32'd0) $display("FAIL clr_mdata got=%h exp=0", mdata_out); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL clr_ready got=%b exp=0", mem_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL clr_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL clr_err got=%b exp=0", err); else n_pass++;
    tick();
    tick();
    clr = 1'b1;
    tick();
    run_access(1'b1, 1'b0, 9'd3, 32'd0);
    n_total++; if (mdata_out !== 32'h0000_0033) $display("FAIL clr_ram3 got=%h exp=00000033", mdata_out); else n_pass++;
    run_access(1'b1, 1'b0, 9'd9, 32'd0);
    n_total++; if (mdata_out !== 32'hA5A5_0009) $display("FAIL clr_ram9 got=%h exp=a5a50009", mdata_out); else n_pass++;
  endtask

  // Requests held high: pulse period is LATENCY+2 edges; position p counts
  // edges since each acceptance (DONE at p=LATENCY, IDLE at p=LATENCY+1).
  task automatic test_back_to_back();
    mar_addr = 9'd5;
    mem_read = 1'b1;
    rd_l1    = 1'b1;
    rd_l15   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_total++; if (mem_ready !== ((i % 4) == 2)) $display("FAIL b2b_l2_ready i=%0d got=%b exp=%b", i, mem_ready, (i % 4) == 2); else n_pass++;
      n_total++; if (busy !== ((i % 4) != 3)) $display("FAIL b2b_l2_busy i=%0d got=%b exp=%b", i, busy, (i % 4) != 3); else n_pass++;
      n_total++; if (ready_l1 !== ((i % 3) == 1)) $display("FAIL b2b_l1_ready i=%0d got=%b exp=%b", i, ready_l1, (i % 3) == 1); else n_pass++;
      n_total++; if (busy_l1 !== ((i % 3) != 2)) $display("FAIL b2b_l1_busy i=%0d got=%b exp=%b", i, busy_l1, (i % 3) != 2); else n_pass++;
      n_total++; if (ready_l15 !== ((i % 17) == 15)) $display("FAIL b2b_l15_ready i=%0d got=%b exp=%b", i, ready_l15, (i % 17) == 15); else n_pass++;
      n_total++; if (busy_l15 !== ((i % 17) != 16)) $display("FAIL b2b_l15_busy i=%0d got=%b exp=%b", i, busy_l15, (i % 17) != 16); else n_pass++;
      if (i >= 2) begin
        n_total++; if (mdata_out !== 32'h0000_0012) $display("FAIL b2b_l2_data i=%0d got=%h exp=00000012", i, mdata_out); else n_pass++;
      end
    end
    mem_read = 1'b0;
    rd_l1    = 1'b0;
    rd_l15   = 1'b0;
    repeat (20) tick();
    n_total++; if (busy_l15 !== 1'b0) $display("FAIL b2b_l15_idle got=%b exp=0", busy_l15); else n_pass++;
    n_total++; if (err_l1 !== 1'b0 || err_l15 !== 1'b0) $display("FAIL b2b_err got=%b%b exp=00", err_l1, err_l15); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_illegal();
    test_wait_ignore();
    test_async_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
